if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core; sits directly upstream of the decode stage and produces `Instruction_id`, `PC_id` and `Valid_id`. It owns the fetch PC and talks to instruction memory through a single-outstanding request/response handshake. It also applies decode-stage redirects (`Branch`/`Jump` with `JumpAddr`) and honours the load-use hold (`IFWrite`). Responses that belong to a squashed fetch are discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `IFWrite` in 1: 1 = IF/ID may advance; 0 = hold IF/ID and ignore redirect.
- `Branch` in 1: taken conditional branch in ID.
- `Jump` in 1: JAL/JALR in ID.
- `JumpAddr` in 32: redirect target.
- `imem_req` out 1: fetch request, accepted by memory in the same cycle.
- `imem_addr` out 32: fetch address, valid while `imem_req`=1.
- `imem_valid` in 1: response strobe, at least 1 cycle after its request.
- `imem_rdata` in 32: instruction word, valid with `imem_valid`.
- `Instruction_id` out 32: IF/ID instruction.
- `PC_id` out 32: IF/ID PC.
- `Valid_id` out 1: 1 = real instruction; 0 = bubble.

## Operation
- Internal state: `pc_f` (address of the current or next request), `buf` (32-bit hold buffer), FSM state `{S_REQ, S_WAIT, S_BUF, S_DROP}`.
- `redirect = (Branch | Jump) & IFWrite`. When `IFWrite`=0, `Branch` and `Jump` are ignored.
- On redirect: `pc_f <= {JumpAddr[31:2],2'b00}`; IF/ID <= {`NOP_INSTR`, PC 0, valid 0}.
- "Bubble" means IF/ID <= {`NOP_INSTR`, 0, 0}. "Hold" means IF/ID unchanged.
- S_REQ
  - `imem_req`=1, `imem_addr`=`pc_f`.
  - If IFWrite=1, IF/ID takes a bubble; otherwise hold.
  - Next state: redirect -> S_DROP; else -> S_WAIT.
- S_WAIT
  - imem_valid=0:
    - redirect -> S_DROP.
    - else IFWrite ? bubble : hold; stay in S_WAIT.
  - imem_valid=1 and redirect: discard `imem_rdata`; -> S_REQ.
  - imem_valid=1 and IFWrite=1:
    - IF/ID <= {`imem_rdata`, `pc_f`, 1}; `pc_f` <= `pc_f`+4.
    - In the same cycle `imem_req`=1, `imem_addr`=`pc_f`+4; stay in S_WAIT (back-to-back fetch).
  - imem_valid=1 and IFWrite=0: `buf` <= `imem_rdata`; hold; -> S_BUF.
- S_BUF
  - `imem_req`=0.
  - redirect: drop `buf`; -> S_REQ.
  - IFWrite=1: IF/ID <= {`buf`, `pc_f`, 1}; `pc_f` += 4; -> S_REQ.
  - Otherwise hold.
- S_DROP
  - `imem_req`=0.
  - IFWrite ? bubble : hold.
  - A new redirect updates `pc_f` only.
  - imem_valid=1: discard the response; -> S_REQ.
- `imem_valid` in S_REQ or S_BUF is a protocol error and is ignored.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Outside the S_REQ and back-to-back-fetch cases above, `imem_req`=0 and `imem_addr` = `pc_f` (don't-care).

## Timing
- Reset (async assert, sync release effect)
  - State S_REQ, `pc_f`=`RESET_PC`, `buf`=0.
  - `Instruction_id`=`NOP_INSTR`, `PC_id`=0, `Valid_id`=0.
  - `imem_req` is forced 0 while `rst_n`=0.
  - First request at `RESET_PC` is issued in the first cycle after release.
- Reset mid-operation: any outstanding request is abandoned; a late `imem_valid` after release arrives in S_REQ and is ignored.
- Latency, memory with 1-cycle response:
  - request at cycle n; IF/ID valid at edge n+2.
  - Steady state is then 1 instruction per cycle.
- Redirect at edge k:
  - IF/ID is a bubble at k.
  - With 1-cycle memory, the target's request goes out at k+1 (from S_WAIT+valid) or k+2 (via S_DROP).
- All outputs except `imem_req`/`imem_addr` are registered. `imem_req`/`imem_addr` are combinational from state, `imem_valid`, `IFWrite`, `Branch` and `Jump`.

## Test plan
- Reset, 1-cycle memory returning `addr`^32'hA5A5_0000:
  - `imem_addr` sequence 0,4,8,…
  - `Valid_id` first high 2 cycles after release with `PC_id`=0; then one per cycle.
- `IFWrite`=0 for 3 cycles while a response arrives:
  - IF/ID holds; `imem_req` stays 0.
  - After release the buffered word appears with the correct PC; no word is lost or duplicated.
- `Jump`=1, `JumpAddr`=32'h0000_0103 while a request is outstanding:
  - Bubble in IF/ID; the stale response is discarded.
  - Next request at 32'h0000_0100.
- `Branch`=1 with `IFWrite`=0: no redirect; fetch order unchanged.
- `RESET_PC`=32'hFFFF_FFF8: fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Memory latency 4 cycles: IF/ID shows bubbles (`Valid_id`=0, `Instruction_id`=0x13) between instructions; exactly one outstanding request at all times.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the RV32I core.
// Keeps one imem request outstanding, applies ID redirects and the load-use hold.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        Valid_id
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_BUF, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcid_q, pcid_d;
  logic        vld_q, vld_d;
  logic        req;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign redirect = (Branch | Jump) & IFWrite;
  assign target   = {JumpAddr[31:2], 2'b00};
  assign pc_inc   = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    instr_d   = instr_q;
    pcid_d    = pcid_q;
    vld_d     = vld_q;
    req       = 1'b0;
    imem_addr = pc_q;
    // Any advancing cycle that loads nothing real inserts a bubble.
    if (IFWrite) begin
      instr_d = NOP_INSTR;
      pcid_d  = 32'd0;
      vld_d   = 1'b0;
    end
    case (state_q)
      S_REQ: begin
        req = 1'b1;
        if (redirect) begin
          pc_d    = target;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!imem_valid) begin
          if (redirect) begin
            pc_d    = target;
            state_d = S_DROP;
          end
        end else if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (IFWrite) begin
          instr_d   = imem_rdata;
          pcid_d    = pc_q;
          vld_d     = 1'b1;
          pc_d      = pc_inc;
          req       = 1'b1;
          imem_addr = pc_inc;
        end else begin
          buf_d   = imem_rdata;
          state_d = S_BUF;
        end
      end
      S_BUF: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (IFWrite) begin
          instr_d = buf_q;
          pcid_d  = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_inc;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // The squashed response must still drain before a new request.
        if (redirect) pc_d = target;
        if (imem_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req = req & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      pcid_q  <= 32'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pcid_q  <= pcid_d;
      vld_q   <= vld_d;
    end
  end

  assign Instruction_id = instr_q;
  assign PC_id          = pcid_q;
  assign Valid_id       = vld_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: a variable-latency memory model, random
// holds/redirects, and an expected program-order PC stream kept in a queue.
module tb_if_fetch_stage;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        IFWrite = 1'b1, Branch = 1'b0, Jump = 1'b0;
  logic [31:0] JumpAddr = 32'd0;
  logic        imem_req, imem_valid, Valid_id;
  logic [31:0] imem_addr, imem_rdata, Instruction_id, PC_id;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .IFWrite(IFWrite), .Branch(Branch), .Jump(Jump),
    .JumpAddr(JumpAddr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .Instruction_id(Instruction_id), .PC_id(PC_id), .Valid_id(Valid_id));

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model: one pending request, answered lat cycles after acceptance.
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic        cap_rst = 1'b0, cap_ifw = 1'b0, cap_redir = 1'b0;

  assign imem_valid = pend && (cnt == 0);
  assign imem_rdata = imem_valid ? (paddr ^ XK) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cap_rst   <= rst_n;
    cap_ifw   <= IFWrite;
    cap_redir <= (Branch | Jump) & IFWrite & rst_n;
    if (!rst_n) begin
      pend <= 1'b0;
    end else begin
      if (pend && cnt != 0) cnt <= cnt - 1;
      if (imem_valid) pend <= 1'b0;
      if (imem_req) begin
        chk("one_outstanding", {31'd0, pend & ~imem_valid}, 32'd0);
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  // Expected program-order stream of delivered PCs.
  logic [31:0] exp_q[$];
  logic [31:0] last_pc;

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(last_pc);
      last_pc = last_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    last_pc = a;
    refill();
  endtask

  logic [31:0] p_instr = NOP, p_pc = 32'd0;
  logic        p_vld = 1'b0;
  int          idle = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    logic        got;
    got = 1'b0;
    if (!rst_n || !cap_rst) begin
      chk("rst_valid", {31'd0, Valid_id}, 32'd0);
      chk("rst_instr", Instruction_id, NOP);
      chk("rst_pc", PC_id, 32'd0);
      if (!rst_n) chk("rst_req", {31'd0, imem_req}, 32'd0);
    end else if (cap_redir) begin
      chk("redir_bubble_v", {31'd0, Valid_id}, 32'd0);
      chk("redir_bubble_i", Instruction_id, NOP);
      chk("redir_bubble_pc", PC_id, 32'd0);
    end else if (!cap_ifw) begin
      chk("hold_v", {31'd0, Valid_id}, {31'd0, p_vld});
      chk("hold_i", Instruction_id, p_instr);
      chk("hold_pc", PC_id, p_pc);
    end else if (Valid_id) begin
      got = 1'b1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_empty: got PC %h expected no delivery", PC_id);
      end else begin
        e = exp_q.pop_front();
        chk("deliv_pc", PC_id, e);
        chk("deliv_instr", Instruction_id, e ^ XK);
      end
    end else begin
      chk("bubble_i", Instruction_id, NOP);
      chk("bubble_pc", PC_id, 32'd0);
    end
    if (!rst_n || got) idle <= 0;
    else if (idle > 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL stall: got %0d idle cycles expected at most 100", idle);
      idle <= 0;
    end else idle <= idle + 1;
    p_instr <= Instruction_id;
    p_pc    <= PC_id;
    p_vld   <= Valid_id;
  end

  task automatic step(input int p_hold, input int p_redir);
    #1;
    IFWrite = ($urandom_range(99) >= p_hold);
    Branch  = 1'b0;
    Jump    = 1'b0;
    if ($urandom_range(99) < p_redir) begin
      if ($urandom_range(1) == 1) Branch = 1'b1;
      else Jump = 1'b1;
      JumpAddr = $urandom;
    end
    if (IFWrite && (Branch || Jump)) restart({JumpAddr[31:2], 2'b00});
    refill();
    @(negedge clk);
  endtask

  task automatic do_reset(input int new_lat);
    @(negedge clk);
    #1;
    rst_n = 1'b0; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    lat = new_lat;
    restart(RPC);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    restart(RPC);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    @(negedge clk);
    chk("lat_v1", {31'd0, Valid_id}, 32'd0);
    @(negedge clk);
    chk("lat_v2", {31'd0, Valid_id}, 32'd1);
    chk("lat_pc2", PC_id, RPC);
    @(negedge clk);
    chk("wrap_pc3", PC_id, RPC + 32'd4);
    @(negedge clk);
    chk("wrap_pc4", PC_id, 32'd0);
    repeat (4) step(0, 0);
    // Jump while a request is outstanding: target fetched word-aligned.
    #1;
    Jump = 1'b1; JumpAddr = 32'h0000_0103;
    restart(32'h0000_0100);
    @(negedge clk);
    chk("jmp_req", {31'd0, imem_req}, 32'd1);
    chk("jmp_addr", imem_addr, 32'h0000_0100);
    #1 Jump = 1'b0;
    @(negedge clk);
    // Branch under hold is ignored; three hold cycles.
    #1;
    IFWrite = 1'b0; Branch = 1'b1; JumpAddr = 32'h0000_5000;
    repeat (3) @(negedge clk);
    #1 IFWrite = 1'b1; Branch = 1'b0;
    repeat (6) step(0, 0);
    repeat (300) step(30, 5);
    do_reset(4);
    repeat (30) step(0, 0);
    repeat (300) step(20, 3);
    do_reset(2);
    repeat (300) step(30, 5);
    do_reset(1);
    repeat (200) step(40, 8);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
